// File: rtl/aged_reservation_station.sv
// rtl/aged_reservation_station.sv - age-ordered reservation station between decoder and one ALU
// Purpose: holds decoded ops until both operands resolve (snooping NUM_BCAST result buses),
//          issues the oldest ready entry to the ALU under backpressure, and forwards ALU
//          completions to the ROB and the broadcast bus.
// Ports:   clk_in/rst_in (async, active-high)/rdy_in (global enable)/flush
//          dec_*        : insert request, operand values/tags, destination tag, immediate; dec_full back
//          bcast_*      : snooped result channels, channel c at [c*W +: W]
//          alu_en/alu_ready and alu_rob_id_in/alu_type/alu_data_j/alu_data_k/alu_imm : issue
//          alu_rdy/alu_rob_id_out/alu_result/alu_set_jump_addr : ALU completion in
//          rob_* and broadcast_* : completion forwarded combinationally
//          count        : occupied entries
module aged_reservation_station #(
    parameter int  RS_DEPTH   = 8,
    parameter int  ROB_WIDTH  = 4,
    parameter int  TYPE_WIDTH = 5,
    parameter int  NUM_BCAST  = 2,
    localparam int CNT_W      = $clog2(RS_DEPTH) + 1
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            flush,
    // decoder side
    input  logic                            dec_rdy,
    output logic                            dec_full,
    input  logic [TYPE_WIDTH-1:0]           dec_type,
    input  logic [31:0]                     dec_data_j,
    input  logic [31:0]                     dec_data_k,
    input  logic                            dec_pending_j,
    input  logic                            dec_pending_k,
    input  logic [ROB_WIDTH-1:0]            dec_dependency_j,
    input  logic [ROB_WIDTH-1:0]            dec_dependency_k,
    input  logic [ROB_WIDTH-1:0]            dec_rob_id,
    input  logic [31:0]                     dec_imm,
    // snooped result buses
    input  logic [NUM_BCAST-1:0]            bcast_en,
    input  logic [NUM_BCAST*ROB_WIDTH-1:0]  bcast_rob_id,
    input  logic [NUM_BCAST*32-1:0]         bcast_data,
    // ALU issue
    output logic                            alu_en,
    input  logic                            alu_ready,
    output logic [ROB_WIDTH-1:0]            alu_rob_id_in,
    output logic [TYPE_WIDTH-1:0]           alu_type,
    output logic [31:0]                     alu_data_j,
    output logic [31:0]                     alu_data_k,
    output logic [31:0]                     alu_imm,
    // ALU completion
    input  logic                            alu_rdy,
    input  logic [ROB_WIDTH-1:0]            alu_rob_id_out,
    input  logic [31:0]                     alu_result,
    input  logic [31:0]                     alu_set_jump_addr,
    // ROB and broadcast forwarding
    output logic                            rob_rdy,
    output logic [ROB_WIDTH-1:0]            rob_rob_id,
    output logic [31:0]                     rob_data,
    output logic [31:0]                     rob_set_jump_addr,
    output logic                            broadcast_en,
    output logic [ROB_WIDTH-1:0]            broadcast_rob_id,
    output logic [31:0]                     broadcast_data,
    output logic [CNT_W-1:0]                count
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam logic [IDX_W-1:0] AGE_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // entry state
    logic [RS_DEPTH-1:0]   present_q, pend_j_q, pend_k_q;
    logic [IDX_W-1:0]      age_q    [RS_DEPTH];
    logic [TYPE_WIDTH-1:0] type_q   [RS_DEPTH];
    logic [31:0]           data_j_q [RS_DEPTH];
    logic [31:0]           data_k_q [RS_DEPTH];
    logic [31:0]           imm_q    [RS_DEPTH];
    logic [ROB_WIDTH-1:0]  dep_j_q  [RS_DEPTH];
    logic [ROB_WIDTH-1:0]  dep_k_q  [RS_DEPTH];
    logic [ROB_WIDTH-1:0]  rob_q    [RS_DEPTH];

    // next-state and helper signals
    logic [RS_DEPTH-1:0]   present_nxt, pend_j_nxt, pend_k_nxt;
    logic [RS_DEPTH-1:0]   ready_vec, wake_j, wake_k;
    logic [IDX_W-1:0]      age_nxt  [RS_DEPTH];
    logic [32:0]           snoop_j  [RS_DEPTH];
    logic [32:0]           snoop_k  [RS_DEPTH];
    logic [32:0]           dec_snoop_j, dec_snoop_k;
    logic [CNT_W-1:0]      count_nxt;
    logic [IDX_W-1:0]      sel_idx, sel_age, free_idx;
    logic                  any_ready, fire, do_insert;

    // Broadcast lookup: {hit, data}. Iterating from the top channel down lets the
    // lowest matching channel index overwrite the result last, so it wins.
    function automatic logic [32:0] snoop(input logic [ROB_WIDTH-1:0] tag);
        logic [32:0] res;
        res = '0;
        for (int c = NUM_BCAST - 1; c >= 0; c--) begin
            if (bcast_en[c] && (bcast_rob_id[c*ROB_WIDTH +: ROB_WIDTH] == tag)) begin
                res = {1'b1, bcast_data[c*32 +: 32]};
            end
        end
        return res;
    endfunction

    assign dec_snoop_j = snoop(dec_dependency_j);
    assign dec_snoop_k = snoop(dec_dependency_k);

    // Readiness uses registered pending bits only, so a woken entry becomes
    // issuable one cycle after the broadcast that woke it.
    assign ready_vec = present_q & ~pend_j_q & ~pend_k_q;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            snoop_j[i] = snoop(dep_j_q[i]);
            snoop_k[i] = snoop(dep_k_q[i]);
            wake_j[i]  = present_q[i] & pend_j_q[i] & snoop_j[i][32];
            wake_k[i]  = present_q[i] & pend_k_q[i] & snoop_k[i][32];
        end
    end

    // Oldest-ready select; ages are unique among present entries so no tie-break needed.
    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ready_vec[i] && (!any_ready || (age_q[i] > sel_age))) begin
                any_ready = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age_q[i];
            end
        end
    end

    // Lowest-index empty slot; only meaningful when not full.
    always_comb begin
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!present_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // dec_full comes from registered occupancy only: a same-cycle issue does not open a slot.
    assign dec_full  = (count == CNT_W'(RS_DEPTH));
    assign alu_en    = any_ready & rdy_in;
    assign fire      = alu_en & alu_ready;
    assign do_insert = dec_rdy & ~dec_full & rdy_in & ~flush;

    always_comb begin
        present_nxt = present_q;
        pend_j_nxt  = pend_j_q & ~wake_j;
        pend_k_nxt  = pend_k_q & ~wake_k;
        if (fire) begin
            present_nxt[sel_idx] = 1'b0;
        end
        if (do_insert) begin
            present_nxt[free_idx] = 1'b1;
            pend_j_nxt[free_idx]  = dec_pending_j & ~dec_snoop_j[32];
            pend_k_nxt[free_idx]  = dec_pending_k & ~dec_snoop_k[32];
        end
    end

    // Rank update: an insert ages everyone by one, a free pulls down everyone older
    // than the freed entry. Applied together the ranks stay 0..count-1.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            age_nxt[i] = age_q[i];
            if (do_insert) begin
                age_nxt[i] = age_nxt[i] + AGE_ONE;
            end
            if (fire && (age_q[i] > sel_age)) begin
                age_nxt[i] = age_nxt[i] - AGE_ONE;
            end
            if (!present_q[i] || (do_insert && (IDX_W'(i) == free_idx))) begin
                age_nxt[i] = '0;
            end
        end
    end

    always_comb begin
        count_nxt = count;
        case ({do_insert, fire})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // control state
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            present_q <= '0;
            pend_j_q  <= '0;
            pend_k_q  <= '0;
            count     <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush) begin
                present_q <= '0;
                pend_j_q  <= '0;
                pend_k_q  <= '0;
                count     <= '0;
                for (int i = 0; i < RS_DEPTH; i++) begin
                    age_q[i] <= '0;
                end
            end else begin
                present_q <= present_nxt;
                pend_j_q  <= pend_j_nxt;
                pend_k_q  <= pend_k_nxt;
                count     <= count_nxt;
                for (int i = 0; i < RS_DEPTH; i++) begin
                    age_q[i] <= age_nxt[i];
                end
            end
        end
    end

    // payload; validity is tracked by present/pending so no reset is needed
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (wake_j[i]) begin
                    data_j_q[i] <= snoop_j[i][31:0];
                end
                if (wake_k[i]) begin
                    data_k_q[i] <= snoop_k[i][31:0];
                end
            end
            if (do_insert) begin
                type_q[free_idx]   <= dec_type;
                imm_q[free_idx]    <= dec_imm;
                rob_q[free_idx]    <= dec_rob_id;
                dep_j_q[free_idx]  <= dec_dependency_j;
                dep_k_q[free_idx]  <= dec_dependency_k;
                data_j_q[free_idx] <= (dec_pending_j && dec_snoop_j[32]) ? dec_snoop_j[31:0] : dec_data_j;
                data_k_q[free_idx] <= (dec_pending_k && dec_snoop_k[32]) ? dec_snoop_k[31:0] : dec_data_k;
            end
        end
    end

    assign alu_rob_id_in     = rob_q[sel_idx];
    assign alu_type          = type_q[sel_idx];
    assign alu_data_j        = data_j_q[sel_idx];
    assign alu_data_k        = data_k_q[sel_idx];
    assign alu_imm           = imm_q[sel_idx];

    assign rob_rdy           = alu_rdy;
    assign rob_rob_id        = alu_rob_id_out;
    assign rob_data          = alu_result;
    assign rob_set_jump_addr = alu_set_jump_addr;
    assign broadcast_en      = alu_rdy;
    assign broadcast_rob_id  = alu_rob_id_out;
    assign broadcast_data    = alu_result;

endmodule

// File: tb/tb_aged_reservation_station.sv
// tb/tb_aged_reservation_station.sv - scoreboard bench for aged_reservation_station
module tb_aged_reservation_station;

    typedef logic [67:0] exp_t;   // {rob_id, data_j, data_k}

    logic        clk = 1'b0;
    logic        rst, rdy, flush, dec_rdy, dec_full;
    logic [4:0]  dec_type;
    logic [31:0] dec_data_j, dec_data_k, dec_imm;
    logic        dec_pending_j, dec_pending_k;
    logic [3:0]  dec_dependency_j, dec_dependency_k, dec_rob_id;
    logic [1:0]  bcast_en;
    logic [7:0]  bcast_rob_id;
    logic [63:0] bcast_data;
    logic        alu_en, alu_ready;
    logic [3:0]  alu_rob_id_in;
    logic [4:0]  alu_type;
    logic [31:0] alu_data_j, alu_data_k, alu_imm;
    logic        alu_rdy;
    logic [3:0]  alu_rob_id_out;
    logic [31:0] alu_result, alu_set_jump_addr;
    logic        rob_rdy, broadcast_en;
    logic [3:0]  rob_rob_id, broadcast_rob_id;
    logic [31:0] rob_data, rob_set_jump_addr, broadcast_data;
    logic [3:0]  count;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    aged_reservation_station dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush(flush),
        .dec_rdy(dec_rdy), .dec_full(dec_full), .dec_type(dec_type),
        .dec_data_j(dec_data_j), .dec_data_k(dec_data_k),
        .dec_pending_j(dec_pending_j), .dec_pending_k(dec_pending_k),
        .dec_dependency_j(dec_dependency_j), .dec_dependency_k(dec_dependency_k),
        .dec_rob_id(dec_rob_id), .dec_imm(dec_imm),
        .bcast_en(bcast_en), .bcast_rob_id(bcast_rob_id), .bcast_data(bcast_data),
        .alu_en(alu_en), .alu_ready(alu_ready), .alu_rob_id_in(alu_rob_id_in),
        .alu_type(alu_type), .alu_data_j(alu_data_j), .alu_data_k(alu_data_k), .alu_imm(alu_imm),
        .alu_rdy(alu_rdy), .alu_rob_id_out(alu_rob_id_out), .alu_result(alu_result),
        .alu_set_jump_addr(alu_set_jump_addr),
        .rob_rdy(rob_rdy), .rob_rob_id(rob_rob_id), .rob_data(rob_data),
        .rob_set_jump_addr(rob_set_jump_addr),
        .broadcast_en(broadcast_en), .broadcast_rob_id(broadcast_rob_id),
        .broadcast_data(broadcast_data), .count(count)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] tag, input logic [31:0] j, input logic [31:0] k);
        return {tag, j, k};
    endfunction

    function automatic exp_t rdy_exp(input logic [3:0] tag);
        return mk(tag, 32'h100 + 32'(tag), 32'h200 + 32'(tag));
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic ins_set(input logic [3:0] tag, input logic pj, input logic [3:0] dj_tag,
                           input logic [31:0] dj, input logic pk, input logic [3:0] dk_tag,
                           input logic [31:0] dk);
        dec_rdy          = 1'b1;
        dec_rob_id       = tag;
        dec_type         = 5'(tag);
        dec_imm          = 32'h1000 + 32'(tag);
        dec_pending_j    = pj;
        dec_dependency_j = dj_tag;
        dec_data_j       = dj;
        dec_pending_k    = pk;
        dec_dependency_k = dk_tag;
        dec_data_k       = dk;
    endtask

    task automatic ins_ready(input logic [3:0] tag);
        ins_set(tag, 1'b0, 4'd0, 32'h100 + 32'(tag), 1'b0, 4'd0, 32'h200 + 32'(tag));
        cyc();
        dec_rdy = 1'b0;
    endtask

    // scoreboard monitor: every accepted issue must match the next expected entry
    always @(negedge clk) begin
        if (!rst && alu_en && alu_ready) begin
            exp_t got;
            exp_t want;
            got = {alu_rob_id_in, alu_data_j, alu_data_k};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected actual=%h expected=none", got);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL issue actual=%h expected=%h", got, want);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; dec_rdy = 1'b0; dec_type = '0;
        dec_data_j = '0; dec_data_k = '0; dec_imm = '0; dec_pending_j = 1'b0; dec_pending_k = 1'b0;
        dec_dependency_j = '0; dec_dependency_k = '0; dec_rob_id = '0;
        bcast_en = '0; bcast_rob_id = '0; bcast_data = '0; alu_ready = 1'b0;
        alu_rdy = 1'b0; alu_rob_id_out = '0; alu_result = '0; alu_set_jump_addr = '0;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_alu_en", 32'(alu_en), 32'd0);
        chk("reset_dec_full", 32'(dec_full), 32'd0);

        // three ready ops issue oldest first in consecutive cycles
        ins_ready(4'd1); ins_ready(4'd2); ins_ready(4'd3);
        chk("t1_count3", 32'(count), 32'd3);
        sb.push_back(rdy_exp(4'd1)); sb.push_back(rdy_exp(4'd2)); sb.push_back(rdy_exp(4'd3));
        alu_ready = 1'b1;
        repeat (3) cyc();
        alu_ready = 1'b0;
        chk("t1_count0", 32'(count), 32'd0);

        // fill, insert while full, then a single issue clears full
        for (int t = 0; t < 8; t++) ins_ready(4'(t));
        chk("t2_count8", 32'(count), 32'd8);
        chk("t2_full", 32'(dec_full), 32'd1);
        ins_ready(4'd15);
        chk("t2_full_count", 32'(count), 32'd8);
        chk("t2_full_hold", 32'(dec_full), 32'd1);
        sb.push_back(rdy_exp(4'd0));
        alu_ready = 1'b1;
        cyc();
        alu_ready = 1'b0;
        chk("t2_not_full", 32'(dec_full), 32'd0);
        chk("t2_count7", 32'(count), 32'd7);
        for (int t = 1; t < 8; t++) sb.push_back(rdy_exp(4'(t)));
        alu_ready = 1'b1;
        repeat (7) cyc();
        alu_ready = 1'b0;
        chk("t2_drained", 32'(count), 32'd0);

        // wakeup on channel 1; not issuable in the broadcast cycle
        ins_set(4'd5, 1'b1, 4'd9, 32'h0, 1'b0, 4'd0, 32'h77);
        cyc();
        dec_rdy = 1'b0;
        chk("t3_pending_no_issue", 32'(alu_en), 32'd0);
        bcast_en = 2'b10; bcast_rob_id = {4'd9, 4'd0}; bcast_data = {32'hDEADBEEF, 32'h0};
        #1;
        chk("t3_same_cycle_no_issue", 32'(alu_en), 32'd0);
        cyc();
        bcast_en = '0;
        chk("t3_woken_alu_en", 32'(alu_en), 32'd1);
        chk("t3_woken_data_j", alu_data_j, 32'hDEADBEEF);
        sb.push_back(mk(4'd5, 32'hDEADBEEF, 32'h77));
        alu_ready = 1'b1;
        cyc();
        alu_ready = 1'b0;

        // two channels match the same tag: lowest channel wins
        ins_set(4'd6, 1'b0, 4'd0, 32'h66, 1'b1, 4'd10, 32'h0);
        cyc();
        dec_rdy = 1'b0;
        bcast_en = 2'b11; bcast_rob_id = {4'd10, 4'd10}; bcast_data = {32'hBBBB0000, 32'hAAAA0000};
        cyc();
        bcast_en = '0;
        sb.push_back(mk(4'd6, 32'h66, 32'hAAAA0000));
        alu_ready = 1'b1;
        cyc();
        alu_ready = 1'b0;

        // capture at insert from a same-cycle broadcast
        ins_set(4'd7, 1'b1, 4'd4, 32'h0, 1'b0, 4'd0, 32'h99);
        bcast_en = 2'b01; bcast_rob_id = {4'd0, 4'd4}; bcast_data = {32'h0, 32'h55};
        cyc();
        dec_rdy = 1'b0; bcast_en = '0;
        chk("t4_captured_ready", 32'(alu_en), 32'd1);
        sb.push_back(mk(4'd7, 32'h55, 32'h99));
        alu_ready = 1'b1;
        cyc();
        alu_ready = 1'b0;

        // backpressure holds the oldest entry
        ins_ready(4'd10); ins_ready(4'd11);
        for (int c = 0; c < 3; c++) begin
            chk("t5_held_tag", 32'(alu_rob_id_in), 32'd10);
            chk("t5_held_count", 32'(count), 32'd2);
            cyc();
        end
        sb.push_back(rdy_exp(4'd10)); sb.push_back(rdy_exp(4'd11));
        alu_ready = 1'b1;
        repeat (2) cyc();
        alu_ready = 1'b0;
        chk("t5_count0", 32'(count), 32'd0);

        // insert and issue in the same cycle keep ranks ordered
        ins_ready(4'd12); ins_ready(4'd13);
        sb.push_back(rdy_exp(4'd12)); sb.push_back(rdy_exp(4'd13)); sb.push_back(rdy_exp(4'd14));
        alu_ready = 1'b1;
        ins_ready(4'd14);
        chk("t6_count_unchanged", 32'(count), 32'd2);
        repeat (2) cyc();
        alu_ready = 1'b0;
        chk("t6_count0", 32'(count), 32'd0);

        // rdy_in low holds everything and masks alu_en
        ins_ready(4'd3);
        rdy = 1'b0;
        #1;
        chk("t7_hold_alu_en", 32'(alu_en), 32'd0);
        alu_ready = 1'b1;
        ins_ready(4'd4);
        chk("t7_hold_count", 32'(count), 32'd1);
        rdy = 1'b1;
        sb.push_back(rdy_exp(4'd3));
        cyc();
        alu_ready = 1'b0;
        chk("t7_count0", 32'(count), 32'd0);

        // flush beats a same-cycle insert
        for (int t = 0; t < 5; t++) ins_ready(4'(t));
        chk("t8_count5", 32'(count), 32'd5);
        flush = 1'b1;
        ins_ready(4'd9);
        flush = 1'b0;
        chk("t8_flush_count", 32'(count), 32'd0);
        chk("t8_flush_alu_en", 32'(alu_en), 32'd0);
        chk("t8_flush_full", 32'(dec_full), 32'd0);

        // asynchronous reset mid-operation
        ins_ready(4'd1); ins_ready(4'd2);
        chk("t9_count2", 32'(count), 32'd2);
        rst = 1'b1;
        #2;
        chk("t9_async_count", 32'(count), 32'd0);
        chk("t9_async_alu_en", 32'(alu_en), 32'd0);
        rst = 1'b0;
        cyc();
        chk("t9_after_count", 32'(count), 32'd0);

        // completion forwarding
        alu_rdy = 1'b1; alu_rob_id_out = 4'd6; alu_result = 32'h1234; alu_set_jump_addr = 32'h400;
        #1;
        chk("fwd_rob_rdy", 32'(rob_rdy), 32'd1);
        chk("fwd_rob_id", 32'(rob_rob_id), 32'd6);
        chk("fwd_rob_data", rob_data, 32'h1234);
        chk("fwd_jump", rob_set_jump_addr, 32'h400);
        chk("fwd_bcast_en", 32'(broadcast_en), 32'd1);
        chk("fwd_bcast_id", 32'(broadcast_rob_id), 32'd6);
        chk("fwd_bcast_data", broadcast_data, 32'h1234);
        alu_rdy = 1'b0;
        cyc();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
